// File: rtl/pipe_seq_ctrl.sv
// pipe_seq_ctrl - registered pipeline sequencer for the 5-stage MIPS core.
// Drives the PC and pipeline-register write-enables and flushes. It resolves
// load-use, ALU-to-branch and load-to-branch hazards, branch/jump redirects
// and data-memory wait freezes.
// A small FSM (RUN / STALL / FREEZE) holds multi-cycle stalls and freezes, so
// they do not depend on live stage fields. Control outputs are combinational
// from the current state and inputs. State, counters and flags change on the
// rising clock edge.
// Optional feature: define PIPE_SEQ_PERF_CNT_EN to build the saturating
// stall/flush/freeze performance counters. Without it those ports read zero.
module pipe_seq_ctrl #(
  parameter int REG_W    = 5,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] IFID_Rs,
  input  logic [REG_W-1:0] IFID_Rt,
  input  logic             IDEX_MemR,
  input  logic             IDEX_RegW,
  input  logic [REG_W-1:0] IDEX_Rd,
  input  logic             Branch,
  input  logic             BrTaken,
  input  logic             jump,
  input  logic             dmem_busy,
  output logic             PCWr,
  output logic             IFIDwr,
  output logic             IDEXWr,
  output logic             EXMEMwr,
  output logic             rstIFID,
  output logic             rstIDEX,
  output logic [1:0]       state_o,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles,
  output logic [CNT_W-1:0] freeze_cycles
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FREEZE = 2'd2
  } state_t;

  // The three pipeline actions the sequencer can request in a cycle
  typedef enum logic [1:0] {
    ACT_GO     = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_HOLD   = 2'd2
  } action_t;

  state_t            state, state_nxt;
  state_t            ret_state, ret_state_nxt;
  logic              stall_cnt, stall_cnt_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              timeout_nxt;
  action_t           action;
  logic              flush_fetch;

  logic rd_match;
  logic load_branch_hz;
  logic alu_branch_hz;
  logic load_use_hz;
  logic redirect;

  // Register 0 is hardwired, so a zero destination can never create a hazard
  assign rd_match = (IDEX_Rd != '0) &&
                    ((IDEX_Rd == IFID_Rs) || (IDEX_Rd == IFID_Rt));

  // A load feeding a branch needs two bubbles: the value only exists after MEM
  assign load_branch_hz = Branch && IDEX_MemR && rd_match;

  // An ALU result feeding the ID-stage comparator needs one bubble
  assign alu_branch_hz  = Branch && IDEX_RegW && !IDEX_MemR && rd_match;

  // A jump reads no registers, so it is excluded from the load-use check
  assign load_use_hz    = !Branch && !jump && IDEX_MemR && rd_match;

  assign redirect       = jump || (Branch && BrTaken);

  assign state_o = state;

  // State register, stall/wait counters, return state and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      ret_state   <= RUN;
      stall_cnt   <= 1'b0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      ret_state   <= ret_state_nxt;
      stall_cnt   <= stall_cnt_nxt;
      wait_cnt    <= wait_cnt_nxt;
      mem_timeout <= timeout_nxt;
    end
  end

  // Next-state logic: pick this cycle's pipeline action and the next FSM values
  always_comb begin
    state_nxt     = state;
    ret_state_nxt = ret_state;
    stall_cnt_nxt = stall_cnt;
    wait_cnt_nxt  = wait_cnt;
    timeout_nxt   = mem_timeout;
    action        = ACT_GO;
    flush_fetch   = 1'b0;

    case (state)
      RUN: begin
        if (dmem_busy) begin
          // A memory stall beats every hazard and redirect
          action        = ACT_HOLD;
          ret_state_nxt = RUN;
          wait_cnt_nxt  = WAIT_ONE;
          state_nxt     = FREEZE;
        end else if (load_branch_hz) begin
          // The second bubble comes from STALL. The branch resolves again afterwards.
          action        = ACT_BUBBLE;
          stall_cnt_nxt = 1'b1;
          state_nxt     = STALL;
        end else if (alu_branch_hz || load_use_hz) begin
          action = ACT_BUBBLE;
        end else if (redirect) begin
          action      = ACT_GO;
          flush_fetch = 1'b1;
        end else begin
          action = ACT_GO;
        end
      end

      STALL: begin
        if (dmem_busy) begin
          // Keep the owed bubble and come back here after the freeze
          action        = ACT_HOLD;
          ret_state_nxt = STALL;
          wait_cnt_nxt  = WAIT_ONE;
          state_nxt     = FREEZE;
        end else begin
          // Redirects are ignored here. RUN sees the branch again next cycle.
          action        = ACT_BUBBLE;
          stall_cnt_nxt = stall_cnt - 1'b1;
          if (stall_cnt_nxt == 1'b0) begin
            state_nxt = RUN;
          end
        end
      end

      FREEZE: begin
        action = ACT_HOLD;
        if (dmem_busy) begin
          if (wait_cnt == WAIT_MAX) begin
            timeout_nxt = 1'b1;
          end else begin
            wait_cnt_nxt = wait_cnt + WAIT_ONE;
          end
        end else begin
          // The release cycle still holds, then we resume where we left off
          wait_cnt_nxt = '0;
          state_nxt    = ret_state;
        end
      end

      default: begin
        action    = ACT_HOLD;
        state_nxt = RUN;
      end
    endcase
  end

  // Output decode: turn the chosen action into enables and flushes, forced safe in reset
  always_comb begin
    PCWr    = 1'b0;
    IFIDwr  = 1'b0;
    IDEXWr  = 1'b0;
    EXMEMwr = 1'b0;
    rstIFID = 1'b0;
    rstIDEX = 1'b0;

    if (rst) begin
      rstIFID = 1'b1;
      rstIDEX = 1'b1;
    end else begin
      case (action)
        ACT_GO: begin
          PCWr    = 1'b1;
          IFIDwr  = 1'b1;
          IDEXWr  = 1'b1;
          EXMEMwr = 1'b1;
          rstIFID = flush_fetch;
        end
        ACT_BUBBLE: begin
          IDEXWr  = 1'b1;
          rstIDEX = 1'b1;
          EXMEMwr = 1'b1;
        end
        default: begin
          PCWr = 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;
  logic [CNT_W-1:0] freeze_q;

  // Saturating event counters for bubbles, fetch squashes and frozen cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q  <= '0;
      flush_q  <= '0;
      freeze_q <= '0;
    end else begin
      if ((action == ACT_BUBBLE) && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (rstIFID && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
      if ((action == ACT_HOLD) && (freeze_q != '1)) begin
        freeze_q <= freeze_q + CNT_W'(1);
      end
    end
  end

  assign stall_cycles  = stall_q;
  assign flush_cycles  = flush_q;
  assign freeze_cycles = freeze_q;
`else
  assign stall_cycles  = '0;
  assign flush_cycles  = '0;
  assign freeze_cycles = '0;
`endif

endmodule
